// File: rtl/eco32_core_pkg.sv
// eco32_core_pkg: constants and types shared by the eco32 core write-back unit.
//   - load size codes (BYTE/HALF/WORD)
//   - return FIFO depth and pointer width
//   - register-file geometry (count, address width, lane layout)
//   - the load-return record carried through the FIFO
package eco32_core_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 8;
  localparam int NUM_REGS   = 32;
  localparam int REG_AW     = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int FIFO_CW    = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // One memory return as queued in the FIFO; formatting happens at drain.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
    logic [1:0]        size;
    logic              sign;
    logic              ins;
    logic [1:0]        off;
  } ld_rsp_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/eco32_core_wbu_lfmt.sv
// eco32_core_wbu_lfmt: combinational load-return formatter.
//   in : m_data  raw aligned memory word
//        size    0 byte, 1 half, 2 word (3 treated as word)
//        sign    sign-extend byte/half in full-word mode
//        ins     lane-insert mode: replicate into lanes, partial byte enables
//        off     byte offset (half uses off[1])
//   out: f_data  value for the register-file write port
//        f_ben   byte-lane enables
module eco32_core_wbu_lfmt
  import eco32_core_pkg::*;
(
  input  logic [XLEN-1:0]      m_data,
  input  logic [1:0]           size,
  input  logic                 sign,
  input  logic                 ins,
  input  logic [1:0]           off,
  output logic [XLEN-1:0]      f_data,
  output logic [NUM_LANES-1:0] f_ben
);

  logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
  logic [LANE_W-1:0]                byte_v;
  logic [2*LANE_W-1:0]              half_v;

  assign lanes  = m_data;
  assign byte_v = lanes[off];
  assign half_v = off[1] ? m_data[31:16] : m_data[15:0];

  always_comb begin
    f_data = m_data;
    f_ben  = '1;
    case (size)
      SZ_BYTE: begin
        if (ins) begin
          f_data = {NUM_LANES{byte_v}};
          f_ben  = 4'b0001 << off;
        end else begin
          f_data = {{(XLEN-LANE_W){sign & byte_v[LANE_W-1]}}, byte_v};
        end
      end
      SZ_HALF: begin
        if (ins) begin
          f_data = {2{half_v}};
          f_ben  = 4'b0011 << {off[1], 1'b0};
        end else begin
          f_data = {{(XLEN-2*LANE_W){sign & half_v[2*LANE_W-1]}}, half_v};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eco32_core_wbu_rfw.sv
// eco32_core_wbu_rfw: write-back unit register-file write arbiter.
// Merges ALU results and formatted memory returns onto one registered
// register-file write port and tracks outstanding loads per register.
//   ALU side   : a_stb/a_ben/a_addr/a_data in, a_hold out (FIFO full)
//   load issue : l_stb/l_addr sets the busy bit of the destination
//   mem return : m_stb/m_addr/m_data/m_size/m_sign/m_ins/m_off in, m_rdy out;
//                queued in a 4-entry FIFO, drained whenever a_stb is low
//   write port : w_ena/w_ben/w_addr/w_data, registered
//   busy       : pending-load scoreboard, one bit per register
// Optional feature macro ECO32_RFW_BYPASS_EN adds byp_ena/byp_addr/byp_data,
// the pre-register write value, valid only for full-word writes.
module eco32_core_wbu_rfw
  import eco32_core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_stb,
  input  logic [3:0]           a_ben,
  input  logic [4:0]           a_addr,
  input  logic [31:0]          a_data,
  output logic                 a_hold,
  input  logic                 l_stb,
  input  logic [4:0]           l_addr,
  input  logic                 m_stb,
  output logic                 m_rdy,
  input  logic [4:0]           m_addr,
  input  logic [31:0]          m_data,
  input  logic [1:0]           m_size,
  input  logic                 m_sign,
  input  logic                 m_ins,
  input  logic [1:0]           m_off,
  output logic                 w_ena,
  output logic [3:0]           w_ben,
  output logic [4:0]           w_addr,
  output logic [31:0]          w_data,
  output logic [31:0]          busy
`ifdef ECO32_RFW_BYPASS_EN
  ,
  output logic                 byp_ena,
  output logic [4:0]           byp_addr,
  output logic [31:0]          byp_data
`endif
);

  // return FIFO
  ld_rsp_t [FIFO_DEPTH-1:0] fifo_q, fifo_d;
  logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0]       cnt_q, cnt_d;
  logic                     push, pop;
  ld_rsp_t                  head;

  // write port / scoreboard
  logic                 w_ena_q, w_ena_d;
  logic [3:0]           w_ben_q, w_ben_d;
  logic [REG_AW-1:0]    w_addr_q, w_addr_d;
  logic [XLEN-1:0]      w_data_q, w_data_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d, busy_set, busy_clr;

  logic [XLEN-1:0]      f_data;
  logic [NUM_LANES-1:0] f_ben;

  assign m_rdy  = (cnt_q < FIFO_CW'(FIFO_DEPTH));
  assign a_hold = (cnt_q == FIFO_CW'(FIFO_DEPTH));
  assign push   = m_stb & m_rdy;
  // ALU owns the port whenever it presents; loads only fill the gaps.
  assign pop    = ~a_stb & (cnt_q != '0);
  assign head   = fifo_q[rd_ptr_q];

  eco32_core_wbu_lfmt u_lfmt (
    .m_data (head.data),
    .size   (head.size),
    .sign   (head.sign),
    .ins    (head.ins),
    .off    (head.off),
    .f_data (f_data),
    .f_ben  (f_ben)
  );

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: m_addr, data: m_data, size: m_size,
                           sign: m_sign, ins: m_ins, off: m_off};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  // Data fields hold their last value on idle cycles; only w_ena drops.
  // Writes to r0 are suppressed but still retire the load below.
  always_comb begin
    w_ena_d  = 1'b0;
    w_ben_d  = w_ben_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (a_stb) begin
      w_ena_d  = (a_addr != '0);
      w_ben_d  = a_ben;
      w_addr_d = a_addr;
      w_data_d = a_data;
    end else if (pop) begin
      w_ena_d  = (head.addr != '0);
      w_ben_d  = f_ben;
      w_addr_d = head.addr;
      w_data_d = f_data;
    end
  end

  // Set wins over clear so a reissued load to the same register stays busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (l_stb && l_addr != '0) busy_set = reg_onehot(l_addr);
    if (pop)                   busy_clr = reg_onehot(head.addr);
    busy_d = (busy_q & ~busy_clr) | busy_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      w_ena_q  <= 1'b0;
      w_ben_q  <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      busy_q   <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      w_ena_q  <= w_ena_d;
      w_ben_q  <= w_ben_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      busy_q   <= busy_d;
    end
  end

  assign w_ena  = w_ena_q;
  assign w_ben  = w_ben_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;
  assign busy   = busy_q;

`ifdef ECO32_RFW_BYPASS_EN
  // Forwarding only makes sense for a complete register value.
  assign byp_ena  = w_ena_d & (w_ben_d == 4'hF);
  assign byp_addr = w_addr_d;
  assign byp_data = w_data_d;
`endif

endmodule

// File: tb/tb_eco32_core_wbu_rfw.sv
module tb_eco32_core_wbu_rfw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_stb;
  logic [3:0]  a_ben;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_hold;
  logic        l_stb;
  logic [4:0]  l_addr;
  logic        m_stb;
  logic        m_rdy;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_size;
  logic        m_sign;
  logic        m_ins;
  logic [1:0]  m_off;
  logic        w_ena;
  logic [3:0]  w_ben;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eco32_core_wbu_rfw dut (
    .clk(clk), .rst_n(rst_n),
    .a_stb(a_stb), .a_ben(a_ben), .a_addr(a_addr), .a_data(a_data), .a_hold(a_hold),
    .l_stb(l_stb), .l_addr(l_addr),
    .m_stb(m_stb), .m_rdy(m_rdy), .m_addr(m_addr), .m_data(m_data),
    .m_size(m_size), .m_sign(m_sign), .m_ins(m_ins), .m_off(m_off),
    .w_ena(w_ena), .w_ben(w_ben), .w_addr(w_addr), .w_data(w_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [4:0] a, input logic [31:0] d, input logic [1:0] sz,
                     input logic sg, input logic in, input logic [1:0] of);
    m_stb = 1'b1; m_addr = a; m_data = d; m_size = sz; m_sign = sg; m_ins = in; m_off = of;
  endtask

  initial begin
    rst_n = 1'b0;
    a_stb = 0; a_ben = 0; a_addr = 0; a_data = 0;
    l_stb = 0; l_addr = 0;
    m_stb = 0; m_addr = 0; m_data = 0; m_size = 0; m_sign = 0; m_ins = 0; m_off = 0;
    #12;
    chk("rst_w_ena", w_ena, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_rdy", m_rdy, 1);
    chk("rst_a_hold", a_hold, 0);
    rst_n = 1'b1;
    step();

    // ALU write, one-cycle latency
    a_stb = 1; a_addr = 5; a_data = 32'h12345678; a_ben = 4'hF;
    step();
    a_stb = 0;
    chk("alu_w_ena", w_ena, 1);
    chk("alu_w_addr", w_addr, 5);
    chk("alu_w_data", w_data, 32'h12345678);
    chk("alu_w_ben", w_ben, 4'hF);
    step();
    chk("idle_w_ena", w_ena, 0);

    // signed byte load to r7, lane 1
    l_stb = 1; l_addr = 7;
    step();
    l_stb = 0;
    chk("busy7_set", busy, 32'h0000_0080);
    ret(7, 32'h0000_80FF, 2'd0, 1, 0, 2'd1);
    step();
    m_stb = 0;
    chk("ld_lat_n1", w_ena, 0);
    chk("busy7_hold", busy, 32'h0000_0080);
    step();
    chk("ld_w_ena", w_ena, 1);
    chk("ld_w_addr", w_addr, 7);
    chk("ld_w_data", w_data, 32'hFFFF_FF80);
    chk("ld_w_ben", w_ben, 4'hF);
    chk("busy7_clr", busy, 0);

    // unsigned half, upper lane
    ret(4, 32'h8765_4321, 2'd1, 0, 0, 2'd2);
    step();
    m_stb = 0;
    step();
    chk("ldh_w_data", w_data, 32'h0000_8765);

    // insert half at offset 2
    ret(3, 32'hABCD_0000, 2'd1, 0, 1, 2'd2);
    step();
    m_stb = 0;
    step();
    chk("ins_w_ena", w_ena, 1);
    chk("ins_w_ben", w_ben, 4'b1100);
    chk("ins_w_hi", {16'h0, w_data[31:16]}, 32'h0000_ABCD);

    // insert byte at offset 3
    ret(6, 32'h5A00_0000, 2'd0, 0, 1, 2'd3);
    step();
    m_stb = 0;
    step();
    chk("insb_w_ben", w_ben, 4'b1000);
    chk("insb_w_data", w_data, 32'h5A5A_5A5A);

    // five returns while the ALU owns the port
    a_stb = 1; a_addr = 1; a_data = 32'h0000_00A1; a_ben = 4'hF;
    for (int i = 0; i < 5; i++) begin
      ret(5'(10 + i), 32'h1000_0000 + i, 2'd2, 0, 0, 2'd0);
      step();
      chk("full_alu_addr", w_addr, 1);
      chk("full_m_rdy", m_rdy, (i < 3) ? 1 : 0);
      chk("full_a_hold", a_hold, (i >= 3) ? 1 : 0);
    end
    a_stb = 0; m_stb = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("drain_w_ena", w_ena, 1);
      chk("drain_w_addr", w_addr, 10 + j);
      chk("drain_w_data", w_data, 32'h1000_0000 + j);
      chk("drain_m_rdy", m_rdy, 1);
    end
    step();
    chk("drain_done", w_ena, 0);

    // ALU write to r0 suppressed
    a_stb = 1; a_addr = 0; a_data = 32'hDEAD_BEEF;
    step();
    a_stb = 0;
    chk("r0_w_ena", w_ena, 0);

    // set and clear of r7 in the same cycle
    l_stb = 1; l_addr = 7;
    step();
    l_stb = 0;
    ret(7, 32'h0000_0011, 2'd2, 0, 0, 2'd0);
    step();
    m_stb = 0;
    l_stb = 1; l_addr = 7;
    step();
    l_stb = 0;
    chk("setclr_w_ena", w_ena, 1);
    chk("setclr_busy7", busy, 32'h0000_0080);

    // mid-operation reset with 3 queued entries
    a_stb = 1; a_addr = 2; a_data = 32'h2;
    l_stb = 1; l_addr = 9;
    for (int k = 0; k < 3; k++) begin
      ret(5'(20 + k), 32'h3000_0000 + k, 2'd2, 0, 0, 2'd0);
      step();
    end
    l_stb = 0; m_stb = 0;
    chk("pre_rst_busy", busy, 32'h0000_0280);
    rst_n = 1'b0;
    #1;
    chk("mrst_w_ena", w_ena, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_m_rdy", m_rdy, 1);
    chk("mrst_a_hold", a_hold, 0);
    a_stb = 0;
    #2;
    rst_n = 1'b1;
    step();
    chk("mrst_drop0", w_ena, 0);
    step();
    chk("mrst_drop1", w_ena, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
